// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg - parametrised oversampling UART receiver.
//
// Samples an asynchronous serial line on a shared baud `tick`
// (OVERSAMPLE ticks per bit). It receives DATA_WIDTH data bits LSB first,
// followed by an optional parity bit and then STOP_BITS stop bits. Each
// received frame goes into an output register with valid/ready handshake.
//
// Ports:
//   clk        in   single clock
//   arst_n     in   synchronous active-low reset, sampled on posedge clk
//   tick       in   one-cycle pulse at OVERSAMPLE x baud
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  received word (DATA_WIDTH bits)
//   rx_valid   out  rx_data / parity_err / frame_err hold a frame
//   rx_ready   in   consumer accepts the held frame
//   parity_err out  parity mismatch for the held frame
//   frame_err  out  a stop bit was sampled low for the held frame
//   overrun    out  one-cycle pulse when a completed frame is dropped
//   state_dbg  out  current receiver FSM state, for observation only
//
// Handshake: the output register holds a frame while rx_valid=1.
// A frame is transferred on every clk edge where rx_valid && rx_ready.
// rx_data and the error flags do not change while rx_valid=1, except
// when a transfer and a new commit happen in the same cycle. The receiver
// FSM never waits for the consumer. If a frame completes while the
// register is still full and not being accepted, that frame is dropped
// and overrun pulses.

module uart_rx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  tick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [2:0]            state_dbg
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam logic [SW-1:0] S_HALF  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_DLAST = NW'(DATA_WIDTH - 1);
    localparam logic [NW-1:0] N_SLAST = NW'(STOP_BITS - 1);
    localparam logic          ODD     = (PARITY_ODD != 0);
    localparam logic          HAS_PAR = (PARITY_EN != 0);

    logic [2:0]            state;
    logic [SW-1:0]         s;
    logic [NW-1:0]         n;
    logic                  rx_q1;
    logic                  rx_s;
    logic [DATA_WIDTH-1:0] sh;
    logic                  par_bad;
    logic                  stop_bad;
    logic                  commit;
    logic                  frame_bad;

    assign state_dbg = state;

    // The last stop sample completes the frame. A low stop sample in
    // that cycle has not reached stop_bad yet, so it is included here.
    assign commit    = tick && (state == ST_STOP) && (s == S_LAST) && (n == N_SLAST);
    assign frame_bad = stop_bad | ~rx_s;

    // Synchronizer and receive FSM
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rx_q1    <= 1'b1;
            rx_s     <= 1'b1;
            state    <= ST_IDLE;
            s        <= '0;
            n        <= '0;
            sh       <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state <= ST_START;
                            s     <= '0;
                        end
                    end
                    ST_START: begin
                        if (s == S_HALF) begin
                            if (rx_s) begin
                                // False start: the line went high again before mid-bit.
                                state <= ST_IDLE;
                                s     <= '0;
                            end else begin
                                state    <= ST_DATA;
                                s        <= '0;
                                n        <= '0;
                                par_bad  <= 1'b0;
                                stop_bad <= 1'b0;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (s == S_LAST) begin
                            // LSB arrives first, so shift in from the top.
                            sh <= {rx_s, sh[DATA_WIDTH-1:1]};
                            s  <= '0;
                            if (n == N_DLAST) begin
                                // n is reused to count stop bits.
                                n     <= '0;
                                state <= HAS_PAR ? ST_PARITY : ST_STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (s == S_LAST) begin
                            par_bad <= (^sh) ^ rx_s ^ ODD;
                            s       <= '0;
                            state   <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (s == S_LAST) begin
                            s <= '0;
                            if (n == N_SLAST) begin
                                n     <= '0;
                                state <= frame_bad ? ST_BREAK : ST_IDLE;
                            end else begin
                                n        <= n + 1'b1;
                                stop_bad <= frame_bad;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        // Wait for the line to return high so that a held-low
                        // line is not seen as a new start bit.
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        s     <= '0;
                        n     <= '0;
                    end
                endcase
            end
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= sh;
                    rx_valid   <= 1'b1;
                    parity_err <= par_bad;
                    frame_err  <= frame_bad;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule
